// File: rtl/ycbcr422_to_rgb.sv
// Pipelined YCbCr 4:2:2 to RGB 4:4:4 converter, BT.601 inverse matrix, 12-bit, 6-cycle latency.
// Optional build macro: YCC2RGB_LIMITED_RANGE_EN selects limited-range input scaling.
module ycbcr422_to_rgb #(
  parameter int CB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Y_in,
  input  logic [11:0] C_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [11:0] R_out,
  output logic [11:0] G_out,
  output logic [11:0] B_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  localparam int LATENCY = 6;
  localparam logic [11:0] CNeutral = 12'd2048;

`ifdef YCC2RGB_LIMITED_RANGE_EN
  localparam logic signed [24:0] KCrR = 25'sd1634;
  localparam logic signed [24:0] KCbG = -25'sd401;
  localparam logic signed [24:0] KCrG = -25'sd832;
  localparam logic signed [24:0] KCbB = 25'sd2066;
`else
  localparam logic signed [24:0] KCrR = 25'sd1436;
  localparam logic signed [24:0] KCbG = -25'sd352;
  localparam logic signed [24:0] KCrG = -25'sd731;
  localparam logic signed [24:0] KCbB = 25'sd1815;
`endif

  // Rounded Q10 descale plus luma; >>> floors negative terms after the bias.
  function automatic logic signed [14:0] descale(input logic signed [24:0] p,
                                                 input logic signed [13:0] y);
    return 15'((p + 25'sd512) >>> 10) + 15'(y);
  endfunction

  function automatic logic [11:0] clamp12(input logic signed [14:0] v);
    if (v < 15'sd0) begin
      return 12'd0;
    end else if (v > 15'sd4095) begin
      return 12'hfff;
    end else begin
      return v[11:0];
    end
  endfunction

  // Chroma phase of the pixel currently at the input
  logic phase_q, phase_d;

  // S1: input capture
  logic [11:0] s1_y_q, s1_y_d, s1_c_q, s1_c_d;
  logic        s1_de_q, s1_de_d, s1_odd_q, s1_odd_d, s1_vld_q, s1_vld_d;

  // S2: pair alignment
  logic [11:0] s2_y_q, s2_y_d, s2_c0_q, s2_c0_d, s2_c1_q, s2_c1_d;
  logic        s2_vld_q, s2_vld_d;

  // S3: offset removal
  logic signed [13:0] s3_y_q, s3_y_d;
  logic signed [12:0] s3_dcb_q, s3_dcb_d, s3_dcr_q, s3_dcr_d;
  logic               s3_vld_q, s3_vld_d;

  // S4: products
  logic signed [13:0] s4_y_q, s4_y_d;
  logic signed [24:0] s4_r_q, s4_r_d, s4_g_q, s4_g_d, s4_b_q, s4_b_d;
  logic               s4_vld_q, s4_vld_d;

  // S5: descale and luma add
  logic signed [14:0] s5_r_q, s5_r_d, s5_g_q, s5_g_d, s5_b_q, s5_b_d;
  logic               s5_vld_q, s5_vld_d;

  // S6: clamped outputs
  logic [11:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic [LATENCY-1:0] hs_q, hs_d, vs_q, vs_d, de_q, de_d;

  logic [11:0] cb, cr;

  always_comb begin
    phase_d = de_in ? ~phase_q : 1'b0;

    s1_y_d   = Y_in;
    s1_c_d   = C_in;
    s1_de_d  = de_in;
    s1_odd_d = de_in & phase_q;
    s1_vld_d = 1'b1;

    // Odd pixel pairs with the even chroma still held in S2; even pixel pairs with
    // the chroma at the input, or neutral if the line ends here.
    s2_y_d   = s1_y_q;
    s2_vld_d = s1_vld_q;
    if (s1_odd_q) begin
      s2_c0_d = s2_c0_q;
      s2_c1_d = s1_c_q;
    end else begin
      s2_c0_d = s1_c_q;
      s2_c1_d = (s1_de_q && de_in) ? C_in : CNeutral;
    end

    cb = (CB_FIRST != 0) ? s2_c0_q : s2_c1_q;
    cr = (CB_FIRST != 0) ? s2_c1_q : s2_c0_q;
    s3_dcb_d = $signed({1'b0, cb}) - 13'sd2048;
    s3_dcr_d = $signed({1'b0, cr}) - 13'sd2048;
    s3_vld_d = s2_vld_q;
`ifdef YCC2RGB_LIMITED_RANGE_EN
    s3_y_d = 14'((25'($signed({2'b00, s2_y_q}) - 14'sd256) * 25'sd1192 + 25'sd512) >>> 10);
`else
    s3_y_d = $signed({2'b00, s2_y_q});
`endif

    s4_y_d   = s3_y_q;
    s4_r_d   = KCrR * 25'(s3_dcr_q);
    s4_g_d   = KCbG * 25'(s3_dcb_q) + KCrG * 25'(s3_dcr_q);
    s4_b_d   = KCbB * 25'(s3_dcb_q);
    s4_vld_d = s3_vld_q;

    s5_r_d   = descale(s4_r_q, s4_y_q);
    s5_g_d   = descale(s4_g_q, s4_y_q);
    s5_b_d   = descale(s4_b_q, s4_y_q);
    s5_vld_d = s4_vld_q;

    // Hold outputs at zero until the first post-reset sample arrives
    r_d = s5_vld_q ? clamp12(s5_r_q) : 12'd0;
    g_d = s5_vld_q ? clamp12(s5_g_q) : 12'd0;
    b_d = s5_vld_q ? clamp12(s5_b_q) : 12'd0;

    hs_d = {hs_q[LATENCY-2:0], hsync_in};
    vs_d = {vs_q[LATENCY-2:0], vsync_in};
    de_d = {de_q[LATENCY-2:0], de_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= 1'b0;
      s1_y_q   <= '0;
      s1_c_q   <= '0;
      s1_de_q  <= 1'b0;
      s1_odd_q <= 1'b0;
      s1_vld_q <= 1'b0;
      s2_y_q   <= '0;
      s2_c0_q  <= '0;
      s2_c1_q  <= '0;
      s2_vld_q <= 1'b0;
      s3_y_q   <= '0;
      s3_dcb_q <= '0;
      s3_dcr_q <= '0;
      s3_vld_q <= 1'b0;
      s4_y_q   <= '0;
      s4_r_q   <= '0;
      s4_g_q   <= '0;
      s4_b_q   <= '0;
      s4_vld_q <= 1'b0;
      s5_r_q   <= '0;
      s5_g_q   <= '0;
      s5_b_q   <= '0;
      s5_vld_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      hs_q     <= '0;
      vs_q     <= '0;
      de_q     <= '0;
    end else begin
      phase_q  <= phase_d;
      s1_y_q   <= s1_y_d;
      s1_c_q   <= s1_c_d;
      s1_de_q  <= s1_de_d;
      s1_odd_q <= s1_odd_d;
      s1_vld_q <= s1_vld_d;
      s2_y_q   <= s2_y_d;
      s2_c0_q  <= s2_c0_d;
      s2_c1_q  <= s2_c1_d;
      s2_vld_q <= s2_vld_d;
      s3_y_q   <= s3_y_d;
      s3_dcb_q <= s3_dcb_d;
      s3_dcr_q <= s3_dcr_d;
      s3_vld_q <= s3_vld_d;
      s4_y_q   <= s4_y_d;
      s4_r_q   <= s4_r_d;
      s4_g_q   <= s4_g_d;
      s4_b_q   <= s4_b_d;
      s4_vld_q <= s4_vld_d;
      s5_r_q   <= s5_r_d;
      s5_g_q   <= s5_g_d;
      s5_b_q   <= s5_b_d;
      s5_vld_q <= s5_vld_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      de_q     <= de_d;
    end
  end

  assign R_out     = r_q;
  assign G_out     = g_q;
  assign B_out     = b_q;
  assign hsync_out = hs_q[LATENCY-1];
  assign vsync_out = vs_q[LATENCY-1];
  assign de_out    = de_q[LATENCY-1];

endmodule

// File: tb/tb_ycbcr422_to_rgb.sv
// Bench for ycbcr422_to_rgb: directed cases plus random lines against a per-cycle history model.
// Honours YCC2RGB_LIMITED_RANGE_EN for the model coefficients.
module tb_ycbcr422_to_rgb;

  localparam int CbFirst = 1;
  localparam int Depth   = 4096;
  localparam int Lat     = 6;

`ifdef YCC2RGB_LIMITED_RANGE_EN
  localparam int KR = 1634, KGB = -401, KGR = -832, KB = 2066;
`else
  localparam int KR = 1436, KGB = -352, KGR = -731, KB = 1815;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] Y_in = '0, C_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
  logic [11:0] R_out, G_out, B_out;
  logic        hsync_out, vsync_out, de_out;

  int errors = 0;
  int checks = 0;
  int t = 0;

  // Inputs as seen at each sampling edge
  int y_h[Depth], c_h[Depth], pos_h[Depth];
  bit de_h[Depth], hs_h[Depth], vs_h[Depth], rst_h[Depth];

  ycbcr422_to_rgb #(.CB_FIRST(CbFirst)) dut (
    .clk       (clk),
    .rst       (rst),
    .Y_in      (Y_in),
    .C_in      (C_in),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .de_in     (de_in),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de_out    (de_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fl1024(input int a);
    return (a >= 0) ? a / 1024 : -((-a + 1023) / 1024);
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 4095) ? 4095 : v);
  endfunction

  function automatic int luma(input int y);
`ifdef YCC2RGB_LIMITED_RANGE_EN
    return fl1024((y - 256) * 1192 + 512);
`else
    return y;
`endif
  endfunction

  // Reference: pair chroma by position within the line, then the BT.601 matrix.
  task automatic model(input int s, output int r, output int g, output int b);
    int c0, c1, dcb, dcr, yy;
    if (pos_h[s] % 2 == 0) begin
      c0 = c_h[s];
      c1 = (de_h[s+1] && !rst_h[s+1]) ? c_h[s+1] : 2048;
    end else begin
      c0 = c_h[s-1];
      c1 = c_h[s];
    end
    dcb = ((CbFirst != 0) ? c0 : c1) - 2048;
    dcr = ((CbFirst != 0) ? c1 : c0) - 2048;
    yy  = luma(y_h[s]);
    r = clamp(yy + fl1024(KR * dcr + 512));
    g = clamp(yy + fl1024(KGB * dcb + KGR * dcr + 512));
    b = clamp(yy + fl1024(KB * dcb + 512));
  endtask

  task automatic check_edge(input int te);
    int  src, r, g, b;
    bit  valid;
    src   = te - (Lat - 1);
    valid = (src >= 0);
    for (int k = 0; k < Lat; k++) begin
      if (te - k >= 0 && rst_h[te-k]) valid = 1'b0;
    end
    chk("hsync_out", 32'(hsync_out), valid ? 32'(hs_h[src]) : 32'd0);
    chk("vsync_out", 32'(vsync_out), valid ? 32'(vs_h[src]) : 32'd0);
    chk("de_out",    32'(de_out),    valid ? 32'(de_h[src]) : 32'd0);
    if (!valid) begin
      chk("rgb_zero", {R_out, G_out, B_out}, 32'd0);
    end else if (de_h[src]) begin
      model(src, r, g, b);
      chk("R_out", 32'(R_out), 32'(r));
      chk("G_out", 32'(G_out), 32'(g));
      chk("B_out", 32'(B_out), 32'(b));
    end
  endtask

  task automatic step(input int y, input int c, input bit h, input bit v, input bit de);
    Y_in     = 12'(y);
    C_in     = 12'(c);
    hsync_in = h;
    vsync_in = v;
    de_in    = de;
    y_h[t]   = y;
    c_h[t]   = c;
    hs_h[t]  = h;
    vs_h[t]  = v;
    de_h[t]  = de;
    rst_h[t] = rst;
    pos_h[t] = (de && t > 0 && de_h[t-1] && !rst_h[t-1]) ? pos_h[t-1] + 1 : 0;
    @(posedge clk);
    #1;
    check_edge(t);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 2048, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int rnd12();
    case ($urandom_range(0, 7))
      0:       return 0;
      1:       return 4095;
      default: return int'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic chk_rgb(input string tag, input int r, input int g, input int b);
    chk({tag, "_R"}, 32'(R_out), 32'(r));
    chk({tag, "_G"}, 32'(G_out), 32'(g));
    chk({tag, "_B"}, 32'(B_out), 32'(b));
  endtask

  initial begin
    int len, gap;

    // Reset held, then released into idle
    idle(8);
    rst = 1'b0;
    idle(8);

    // Neutral grey line; first output appears exactly 6 cycles after the first input
    for (int i = 0; i < 8; i++) begin
      step(2048, 2048, 1'b0, 1'b0, 1'b1);
      if (i == 4) chk("grey_not_early", 32'(de_out), 32'd0);
      if (i == 5) begin
        chk("grey_first_de", 32'(de_out), 32'd1);
`ifndef YCC2RGB_LIMITED_RANGE_EN
        chk_rgb("grey", 2048, 2048, 2048);
`endif
      end
    end
    idle(8);

    // Bright pair with saturated Cr
    step(4095, 2048, 1'b0, 1'b0, 1'b1);
    step(4095, 4095, 1'b0, 1'b0, 1'b1);
    idle(4);
`ifndef YCC2RGB_LIMITED_RANGE_EN
    chk_rgb("bright_p0", 4095, 2634, 4095);
`endif
    idle(1);
`ifndef YCC2RGB_LIMITED_RANGE_EN
    chk_rgb("bright_p1", 4095, 2634, 4095);
`endif
    idle(4);

    // Black with minimum chroma: negatives clamp
    step(0, 0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 1'b0, 1'b0, 1'b1);
    idle(4);
`ifndef YCC2RGB_LIMITED_RANGE_EN
    chk_rgb("black_p0", 0, 2166, 0);
`endif
    idle(1);
`ifndef YCC2RGB_LIMITED_RANGE_EN
    chk_rgb("black_p1", 0, 2166, 0);
`endif
    idle(4);

    // Odd-length line: third pixel gets neutral Cr
    step(1000, 3000, 1'b0, 1'b0, 1'b1);
    step(1000, 2048, 1'b0, 1'b0, 1'b1);
    step(1000, 3000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1);
`ifndef YCC2RGB_LIMITED_RANGE_EN
      if (i >= 2) chk_rgb("odd_line", 1000, 673, 2687);
`endif
    end
    idle(4);

    // hsync pulse with a 20-pixel de burst
    for (int i = 0; i < 20; i++) begin
      step(rnd12(), rnd12(), i == 0, 1'b0, 1'b1);
      if (i == 4) chk("hs_before", 32'(hsync_out), 32'd0);
      if (i == 5) chk("hs_pulse", 32'(hsync_out), 32'd1);
      if (i == 6) chk("hs_after", 32'(hsync_out), 32'd0);
    end
    for (int j = 0; j < 6; j++) begin
      idle(1);
      if (j == 4) chk("de_last", 32'(de_out), 32'd1);
      if (j == 5) chk("de_end", 32'(de_out), 32'd0);
    end
    idle(4);

    // Reset in the middle of a burst, then a fresh line
    for (int i = 0; i < 26; i++) begin
      step(rnd12(), rnd12(), 1'b0, 1'b1, 1'b1);
      if (i == 5) begin
        rst = 1'b1;
        #1;
        chk("rst_async_rgb", {R_out, G_out, B_out}, 32'd0);
        chk("rst_async_hs", 32'(hsync_out), 32'd0);
        chk("rst_async_vs", 32'(vsync_out), 32'd0);
        chk("rst_async_de", 32'(de_out), 32'd0);
      end
      if (i == 7) rst = 1'b0;
    end
    idle(8);

    // Random lines of varied length, including single-cycle gaps
    for (int ln = 0; ln < 30; ln++) begin
      len = int'($urandom_range(1, 15));
      gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) step(rnd12(), rnd12(), g == 0, ln % 10 == 0, 1'b0);
      for (int p = 0; p < len; p++) step(rnd12(), rnd12(), 1'b0, 1'b0, 1'b1);
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
